// File: rtl/adc_sample_fifo.sv
// 16-deep ADC sample FIFO with a simple register bus: pushes from the SPI front end, pops on DATA reads.
// Read data is combinational in the rd cycle; a full FIFO drops pushes and sets a sticky overflow flag.
module adc_sample_fifo #(
  parameter int C_S_AXI_ADDR_WIDTH = 9,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int DEPTH_LOG2         = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [15:0]                   sample_in,
  input  logic                          sample_valid,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] wrAddr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wrData,
  input  logic                          wr,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] rdAddr,
  input  logic                          rd,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rdData,
  output logic                          fifo_irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_DATA   = C_S_AXI_ADDR_WIDTH'(8'h00);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_STATUS = C_S_AXI_ADDR_WIDTH'(8'h04);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_CTRL   = C_S_AXI_ADDR_WIDTH'(8'h08);
  localparam logic [C_S_AXI_ADDR_WIDTH-1:0] A_THRESH = C_S_AXI_ADDR_WIDTH'(8'h0C);

  logic [15:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [4:0]            thresh_q, thresh_d;
  logic                  irq_q, irq_d;

  logic        full_w, empty_w, pop_w, push_ok_w, flush_w, clr_ovf_w;
  logic [31:0] status_w, rd_word_w;
  logic        unused_wrdata;

  assign full_w    = (count_q == CW'(DEPTH));
  assign empty_w   = (count_q == '0);
  assign pop_w     = rd && (rdAddr == A_DATA) && !empty_w;
  // A full FIFO still accepts a push when the same cycle pops.
  assign push_ok_w = sample_valid && (!full_w || pop_w);
  assign flush_w   = wr && (wrAddr == A_CTRL) && wrData[0];
  assign clr_ovf_w = wr && (wrAddr == A_CTRL) && wrData[1];

  assign unused_wrdata = ^wrData[C_S_AXI_DATA_WIDTH-1:5];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    thresh_d = thresh_q;
    if (flush_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_w) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_w)     rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      count_d = count_q + CW'(push_ok_w) - CW'(pop_w);
    end
    // Set wins over a same-cycle clear.
    if (sample_valid && full_w && !pop_w) ovf_d = 1'b1;
    else if (clr_ovf_w)                   ovf_d = 1'b0;
    if (wr && (wrAddr == A_THRESH)) thresh_d = wrData[4:0];
    irq_d = (thresh_q != 5'd0) && (32'(count_q) >= 32'(thresh_q));
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      thresh_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      thresh_q <= thresh_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok_w && !flush_w) mem_q[wr_ptr_q] <= sample_in;
  end

  always_comb begin
    status_w        = '0;
    status_w[10]    = ovf_q;
    status_w[9]     = full_w;
    status_w[8]     = empty_w;
    status_w[4:0]   = 5'(count_q);
    rd_word_w       = '0;
    case (rdAddr)
      A_DATA:   rd_word_w = empty_w ? 32'h0 : {1'b1, 15'b0, mem_q[rd_ptr_q]};
      A_STATUS: rd_word_w = status_w;
      A_THRESH: rd_word_w = {27'b0, thresh_q};
      default:  rd_word_w = '0;
    endcase
  end

  assign rdData   = C_S_AXI_DATA_WIDTH'(rd_word_w);
  assign fifo_irq = irq_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Scoreboard bench for adc_sample_fifo: a queue model of the FIFO predicts every read and the irq.
module tb_adc_sample_fifo;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [8:0]  wrAddr, rdAddr;
  logic [31:0] wrData, rdData;
  logic        wr, rd, fifo_irq;

  always #5 clk = ~clk;

  adc_sample_fifo dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .wrAddr(wrAddr), .wrData(wrData), .wr(wr),
    .rdAddr(rdAddr), .rd(rd), .rdData(rdData), .fifo_irq(fifo_irq)
  );

  localparam logic [8:0] A_DATA = 9'h00, A_STAT = 9'h04, A_CTRL = 9'h08, A_THR = 9'h0C, A_BAD = 9'h10;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb_q [$];
  logic        m_ovf = 1'b0;
  logic [4:0]  m_thr = 5'd0;
  logic [31:0] rv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    int n;
    n = sb_q.size();
    return {21'b0, m_ovf, n == 16, n == 0, 3'b0, 5'(n)};
  endfunction

  // One bus cycle: drive at negedge, check combinational read, update model, check irq after the edge.
  task automatic cyc(input logic sv, input logic [15:0] s, input logic r, input logic [8:0] ra,
                     input logic w, input logic [8:0] wa, input logic [31:0] wd, output logic [31:0] rdv);
    logic        pop, flush, clr, irq_exp;
    logic [31:0] exp_rd;
    int          cnt;
    @(negedge clk);
    sample_valid = sv; sample_in = s; rd = r; rdAddr = ra; wr = w; wrAddr = wa; wrData = wd;
    #1 rdv = rdData;
    cnt    = sb_q.size();
    exp_rd = 32'h0;
    if (r) begin
      if (ra == A_DATA && cnt > 0) exp_rd = {1'b1, 15'b0, sb_q[0]};
      else if (ra == A_STAT)       exp_rd = m_status();
      else if (ra == A_THR)        exp_rd = {27'b0, m_thr};
      chk("rd_model", rdv, exp_rd);
    end
    pop     = r && (ra == A_DATA) && (cnt > 0);
    flush   = w && (wa == A_CTRL) && wd[0];
    clr     = w && (wa == A_CTRL) && wd[1];
    irq_exp = (m_thr != 5'd0) && (cnt >= int'(m_thr));
    if (sv && cnt == 16 && !pop) m_ovf = 1'b1;
    else if (clr)                m_ovf = 1'b0;
    if (w && wa == A_THR) m_thr = wd[4:0];
    if (flush) sb_q.delete();
    else begin
      if (pop) void'(sb_q.pop_front());
      if (sv && (cnt < 16 || pop)) sb_q.push_back(s);
    end
    @(posedge clk);
    #1;
    chk("irq", {31'b0, fifo_irq}, {31'b0, irq_exp});
    sample_valid = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic push(input logic [15:0] s);
    logic [31:0] d;
    cyc(1'b1, s, 1'b0, A_DATA, 1'b0, A_DATA, 32'h0, d);
  endtask

  task automatic rd_reg(input logic [8:0] a, output logic [31:0] d);
    cyc(1'b0, 16'h0, 1'b1, a, 1'b0, A_DATA, 32'h0, d);
  endtask

  task automatic wr_reg(input logic [8:0] a, input logic [31:0] v);
    logic [31:0] d;
    cyc(1'b0, 16'h0, 1'b0, A_DATA, 1'b1, a, v, d);
  endtask

  task automatic idle();
    logic [31:0] d;
    cyc(1'b0, 16'h0, 1'b0, A_DATA, 1'b0, A_DATA, 32'h0, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0; rd = 1'b1; rdAddr = A_STAT;
    #1 chk("rst_status", rdData, 32'h0000_0100);
    chk("rst_irq", {31'b0, fifo_irq}, 32'h0);
    rdAddr = A_DATA;
    #1 chk("rst_data", rdData, 32'h0);
    rd = 1'b0;
    sb_q.delete(); m_ovf = 1'b0; m_thr = 5'd0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
    wrAddr = '0; wrData = '0; wr = 1'b0; rdAddr = '0; rd = 1'b0;
    do_reset();

    // Single push then read.
    push(16'h1234);
    rd_reg(A_DATA, rv); chk("first_data", rv, 32'h8000_1234);
    rd_reg(A_STAT, rv); chk("empty_status", rv, 32'h0000_0100);

    // Threshold above depth never raises the irq, even at full.
    wr_reg(A_THR, 32'd17);
    rd_reg(A_THR, rv); chk("thresh_rb", rv, 32'h0000_0011);

    // Fill, overflow, drain in order, then read of empty.
    for (int i = 0; i < 16; i++) push(16'(i));
    push(16'hBEEF);
    rd_reg(A_STAT, rv); chk("ovf_status", rv, 32'h0000_0610);
    for (int i = 0; i < 16; i++) begin
      rd_reg(A_DATA, rv); chk("drain", rv, 32'h8000_0000 | 32'(i));
    end
    rd_reg(A_DATA, rv); chk("empty_data", rv, 32'h0);
    rd_reg(A_STAT, rv); chk("empty_ovf", rv, 32'h0000_0500);
    wr_reg(A_CTRL, 32'h2);
    wr_reg(A_THR, 32'h0);

    // Undefined addresses: read zero, write ignored.
    push(16'h0042);
    cyc(1'b0, 16'h0, 1'b1, A_BAD, 1'b1, A_BAD, 32'hFFFF_FFFF, rv); chk("bad_addr", rv, 32'h0);
    rd_reg(A_STAT, rv); chk("bad_no_effect", rv, 32'h0000_0001);
    rd_reg(A_DATA, rv);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) push(16'h0100 + 16'(i));
    cyc(1'b1, 16'hAAAA, 1'b1, A_DATA, 1'b0, A_DATA, 32'h0, rv); chk("full_pushpop", rv, 32'h8000_0100);
    rd_reg(A_STAT, rv); chk("full_pp_status", rv, 32'h0000_0210);
    for (int i = 0; i < 16; i++) rd_reg(A_DATA, rv);
    chk("aaaa_last", rv, 32'h8000_AAAA);

    // Simultaneous push and pop at count 1.
    push(16'h0055);
    cyc(1'b1, 16'h0066, 1'b1, A_DATA, 1'b0, A_DATA, 32'h0, rv); chk("one_pushpop", rv, 32'h8000_0055);
    rd_reg(A_STAT, rv); chk("one_pp_status", rv, 32'h0000_0001);
    rd_reg(A_DATA, rv); chk("one_pp_data", rv, 32'h8000_0066);

    // IRQ rise and fall timing.
    wr_reg(A_THR, 32'd4);
    for (int i = 0; i < 4; i++) push(16'h0200 + 16'(i));
    chk("irq_pre", {31'b0, fifo_irq}, 32'h0);
    idle(); chk("irq_rise", {31'b0, fifo_irq}, 32'h1);
    rd_reg(A_DATA, rv); chk("irq_hold", {31'b0, fifo_irq}, 32'h1);
    idle(); chk("irq_fall", {31'b0, fifo_irq}, 32'h0);
    wr_reg(A_THR, 32'h0);

    // Flush plus overflow clear with a same-cycle push.
    wr_reg(A_CTRL, 32'h1);
    for (int i = 0; i < 10; i++) push(16'h0300 + 16'(i));
    cyc(1'b1, 16'h7777, 1'b0, A_DATA, 1'b1, A_CTRL, 32'h3, rv);
    rd_reg(A_STAT, rv); chk("flush_status", rv, 32'h0000_0100);
    rd_reg(A_DATA, rv); chk("flush_lost", rv, 32'h0);

    // Overflow set wins over clear; flush beats a same-cycle pop.
    for (int i = 0; i < 16; i++) push(16'h0400 + 16'(i));
    cyc(1'b1, 16'h1111, 1'b0, A_DATA, 1'b1, A_CTRL, 32'h2, rv);
    rd_reg(A_STAT, rv); chk("set_wins", rv, 32'h0000_0610);
    cyc(1'b0, 16'h0, 1'b1, A_DATA, 1'b1, A_CTRL, 32'h1, rv); chk("flush_pop_data", rv, 32'h8000_0400);
    rd_reg(A_STAT, rv); chk("flush_pop_status", rv, 32'h0000_0500);
    wr_reg(A_CTRL, 32'h2);

    // Reset mid-operation with irq active.
    wr_reg(A_THR, 32'd4);
    for (int i = 0; i < 7; i++) push(16'h0500 + 16'(i));
    idle(); chk("irq_before_rst", {31'b0, fifo_irq}, 32'h1);
    do_reset();
    rd_reg(A_STAT, rv); chk("post_rst_status", rv, 32'h0000_0100);
    push(16'hCAFE);
    rd_reg(A_DATA, rv); chk("post_rst_data", rv, 32'h8000_CAFE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_fifo.md
ADC_SAMPLE_FIFO -- requirements
Module: adc_sample_fifo

Interface
REQ-001 Parameter C_S_AXI_ADDR_WIDTH, default 9, sets the simple-bus address width.
REQ-002 Parameter C_S_AXI_DATA_WIDTH, default 32, sets the simple-bus data width.
REQ-003 Parameter DEPTH_LOG2, default 4, sets the FIFO depth to 2^DEPTH_LOG2 sample words (16).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low. Clock and reset are named S_AXI_ACLK and S_AXI_ARESETN.
REQ-005 Ports SHALL be as follows (name, direction, width, meaning):
- S_AXI_ACLK  in  1  system clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- sample_in  in  16  ADC word from the upstream SPI master; MSB-first capture is already resolved upstream.
- sample_valid  in  1  one-cycle strobe; sample_in is valid on this cycle (end of SPI frame).
- wrAddr  in  C_S_AXI_ADDR_WIDTH  simple-bus write address.
- wrData  in  C_S_AXI_DATA_WIDTH  simple-bus write data.
- wr  in  1  simple-bus write strobe, one cycle.
- rdAddr  in  C_S_AXI_ADDR_WIDTH  simple-bus read address.
- rd  in  1  simple-bus read strobe, one cycle.
- rdData  out  C_S_AXI_DATA_WIDTH  read data, combinational, valid in the same cycle as rd.
- fifo_irq  out  1  registered level interrupt: count at or above threshold.

Function
REQ-006 Register map (byte addresses) SHALL be: 0x00 DATA (R), 0x04 STATUS (R), 0x08 CTRL (W), 0x0C THRESH (R/W, bits [4:0]).
REQ-007 Push: a sample_valid cycle while not full SHALL write sample_in at the write pointer, advance the write pointer mod 16, and increment count.
REQ-008 Read of DATA with rd=1 while not empty SHALL return {1'b1, 15'b0, head[15:0]} and pop (read pointer +1 mod 16, count -1) on that clock edge.
REQ-009 Read of DATA while empty SHALL return 32'h0 and leave pointers and count unchanged.
REQ-010 STATUS SHALL read {21'b0, overflow[10], full[9], empty[8], 3'b0, count[4:0]}; count ranges 0..16 (5 bits). Reading STATUS SHALL NOT pop.
REQ-011 Reads of undefined addresses SHALL return 32'h0, with no side effects; writes to undefined addresses SHALL be ignored.
REQ-012 Simultaneous push and pop SHALL complete both, leaving count unchanged, including when full (the popped word is returned and the new word is stored) and when count=1.
REQ-013 Push while full without a same-cycle pop SHALL discard the sample and set sticky overflow.
REQ-014 CTRL write bit0 (flush) SHALL zero the pointers and count on that edge. A same-cycle push SHALL be discarded. A same-cycle DATA read returns the current head; flush takes precedence over that pop.
REQ-015 CTRL write bit1 SHALL clear overflow. If an overflowing push occurs in the same cycle, overflow SHALL remain set (set wins).
REQ-016 fifo_irq SHALL be registered: it asserts the cycle after count >= THRESH with THRESH != 0, and is 0 whenever THRESH = 0.
REQ-017 The THRESH value written SHALL be wrData[4:0]; values above 16 keep fifo_irq low.
REQ-018 Pointers SHALL be DEPTH_LOG2 bits wide and wrap from 15 to 0; full is count==16 and empty is count==0.
REQ-019 Storage SHALL be a register array with no reset requirement on its contents; data reads are gated by empty.

Reset
REQ-020 While S_AXI_ARESETN=0, asynchronously: pointers=0, count=0, overflow=0, THRESH=0, fifo_irq=0. rdData SHALL reflect the reset state (empty; DATA reads 0).
REQ-021 Reset asserted mid-operation SHALL discard all stored samples. The first sample_valid after release SHALL be stored at index 0.

Verification
REQ-022 Reset, then push 0x1234, then read DATA -> rdData=0x80001234; next STATUS read -> 0x00000100 (empty).
REQ-023 Push 16 samples 0x0000..0x000F, then a 17th (0xBEEF) -> STATUS=0x00000610 (overflow, full, count 16); 16 DATA reads return 0x80000000..0x8000000F in order; the next read returns 0.
REQ-024 Full FIFO, same-cycle push 0xAAAA and DATA read -> returns oldest word, count stays 16, overflow stays 0; 0xAAAA is read last.
REQ-025 THRESH=4, push 4 samples -> fifo_irq rises one cycle after the 4th push; one pop -> fifo_irq falls the cycle after.
REQ-026 10 samples stored, CTRL=0x3 written with a same-cycle push -> count=0, overflow=0, and the pushed sample is lost; STATUS reads 0x00000100.
REQ-027 Reset pulsed with 7 samples stored -> STATUS reads 0x00000100 immediately, and fifo_irq=0.
